// File: rtl/ah_pl2cpu_result_fifo_pkg.sv
// Shared constants for the PL-to-CPU result FIFO: status word layout and
// read_ack / rd_words word indices.
package ah_pl2cpu_result_fifo_pkg;

    localparam int unsigned STAT_WIDTH     = 32;
    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_COUNT_W   = 16;
    localparam int unsigned STAT_EMPTY_BIT = 16;
    localparam int unsigned STAT_FULL_BIT  = 17;
    localparam int unsigned STAT_OVF_BIT   = 18;
    localparam int unsigned STAT_UDF_BIT   = 19;
    localparam int unsigned STAT_DROP_LSB  = 24;
    localparam int unsigned DROP_CNT_W     = 8;

    localparam int unsigned WORD_DATA   = 0;
    localparam int unsigned WORD_STATUS = 1;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/ah_pl2cpu_regfile.sv
// Simple dual-port register array: synchronous write, asynchronous read,
// storage deliberately left without reset.
module ah_pl2cpu_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge S_AXI_ACLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ah_pl2cpu_result_fifo.sv
// Result FIFO feeding the CPU-read AXI-Lite slave: word 0 is the FIFO head,
// word 1 is status; read_ack pulses pop the head or clear sticky flags.
module ah_pl2cpu_result_fifo
    import ah_pl2cpu_result_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    flush,
    output logic [2*DATA_WIDTH-1:0] rd_words,
    input  logic [1:0]              read_ack
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic [DROP_CNT_W-1:0] drop_cnt;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  udf_evt;
    logic                  stat_clr;
    logic [DROP_CNT_W-1:0] drop_cnt_nxt;
    logic [DATA_WIDTH-1:0] head_data;
    logic [STAT_WIDTH-1:0] status;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = ~full;

    assign push     = wr_valid & ~full & ~flush;
    assign drop     = wr_valid &  full & ~flush;
    assign pop      = read_ack[WORD_DATA] & ~empty & ~flush;
    assign udf_evt  = read_ack[WORD_DATA] &  empty & ~flush;
    assign stat_clr = read_ack[WORD_STATUS];

    // Clear first, then let a same-cycle drop count from the cleared value.
    always_comb begin
        drop_cnt_nxt = stat_clr ? '0 : drop_cnt;
        if (drop && (drop_cnt_nxt != DROP_CNT_MAX)) begin
            drop_cnt_nxt = drop_cnt_nxt + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
            overflow  <= (overflow  & ~stat_clr) | drop;
            underflow <= (underflow & ~stat_clr) | udf_evt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

    ah_pl2cpu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .S_AXI_ACLK (S_AXI_ACLK),
        .we         (push),
        .waddr      (wr_ptr),
        .wdata      (wr_data),
        .raddr      (rd_ptr),
        .rdata      (head_data)
    );

    always_comb begin
        status = '0;
        status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
        status[STAT_EMPTY_BIT]                 = empty;
        status[STAT_FULL_BIT]                  = full;
        status[STAT_OVF_BIT]                   = overflow;
        status[STAT_UDF_BIT]                   = underflow;
        status[STAT_DROP_LSB +: DROP_CNT_W]    = drop_cnt;
    end

    assign rd_words[WORD_DATA*DATA_WIDTH   +: DATA_WIDTH] = empty ? '0 : head_data;
    assign rd_words[WORD_STATUS*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(status);

endmodule

// File: tb/tb_ah_pl2cpu_result_fifo.sv
// Self-checking bench for ah_pl2cpu_result_fifo against a queue-based model.
module tb_ah_pl2cpu_result_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        flush;
    logic [63:0] rd_words;
    logic [1:0]  read_ack;

    int errors = 0;
    int checks = 0;

    // Behavioural model
    logic [31:0] q[$];
    bit          m_ovf;
    bit          m_udf;
    int          m_drop;

    ah_pl2cpu_result_fifo dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .flush         (flush),
        .rd_words      (rd_words),
        .read_ack      (read_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_words();
        logic [31:0] st;
        logic [31:0] d;
        int n;
        n = q.size();
        d = (n != 0) ? q[0] : 32'h0;
        st = 32'(n);
        st[16] = (n == 0);
        st[17] = (n == 16);
        st[18] = m_ovf;
        st[19] = m_udf;
        st[31:24] = 8'(m_drop);
        return {st, d};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_drop = 0;
    endfunction

    function automatic void model_step(input logic wv, input logic [31:0] wd,
                                       input logic [1:0] ack, input logic fl);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (fl) begin
            q.delete();
        end else begin
            if (ack[0] && !was_empty) void'(q.pop_front());
            if (wv && !was_full) q.push_back(wd);
        end
        if (ack[1]) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_drop = 0;
        end
        if (wv && was_full && !fl) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop = m_drop + 1;
        end
        if (ack[0] && was_empty && !fl) m_udf = 1'b1;
    endfunction

    // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic wv, input logic [31:0] wd,
                        input logic [1:0] ack, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        read_ack = ack;
        flush    = fl;
        model_step(wv, wd, ack, fl);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        read_ack = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 32'h0, 2'b00, 1'b0);
        checks++;
        if (rd_words !== 64'h0001_0000_0000_0000) begin
            errors++;
            $display("FAIL reset_words: got %h want %h", rd_words, 64'h0001_0000_0000_0000);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] vals [3];
        logic [31:0] heads [3];
        vals[0] = 32'hA1; vals[1] = 32'hB2; vals[2] = 32'hC3;
        heads[0] = 32'hB2; heads[1] = 32'hC3; heads[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vals[i], 2'b00, 1'b0);
            checks++;
            if (rd_words[31:0] !== 32'hA1) begin
                errors++;
                $display("FAIL basic_head push%0d: got %h want %h", i, rd_words[31:0], 32'hA1);
            end
        end
        checks++;
        if (rd_words[63:32] !== 32'h0000_0003) begin
            errors++;
            $display("FAIL basic_count3: got %h want %h", rd_words[63:32], 32'h3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 2'b01, 1'b0);
            checks++;
            if (rd_words[31:0] !== heads[i] || rd_words !== exp_words()) begin
                errors++;
                $display("FAIL basic_pop%0d: got %h want %h", i, rd_words, exp_words());
            end
        end
        checks++;
        if (rd_words[63:32] !== 32'h0001_0000) begin
            errors++;
            $display("FAIL basic_empty: got %h want %h", rd_words[63:32], 32'h0001_0000);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, $urandom, 2'b00, 1'b0);
            if (i == 15) begin
                checks++;
                if (wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_wr_ready_after16: got %b want 0", wr_ready);
                end
            end
        end
        checks++;
        if (rd_words[63:32] !== 32'h0106_0010 || rd_words !== exp_words()) begin
            errors++;
            $display("FAIL ovf_status: got %h want %h", rd_words, {32'h0106_0010, exp_words()[31:0]});
        end
        step(1'b0, 32'h0, 2'b10, 1'b0);
        checks++;
        if (rd_words[63:32] !== 32'h0002_0010) begin
            errors++;
            $display("FAIL ovf_clear: got %h want %h", rd_words[63:32], 32'h0002_0010);
        end
        step(1'b0, 32'h0, 2'b00, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, 2'b01, 1'b0);
            checks++;
            if (rd_words !== exp_words() || rd_words[47:32] !== 16'd8) begin
                errors++;
                $display("FAIL wrap_cycle%0d: got %h want %h", i, rd_words, exp_words());
            end
        end
        // Drain and confirm order across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 2'b01, 1'b0);
            checks++;
            if (rd_words !== exp_words()) begin
                errors++;
                $display("FAIL wrap_drain%0d: got %h want %h", i, rd_words, exp_words());
            end
        end
    endtask

    task automatic test_underflow_and_clear_race();
        logic [31:0] w;
        step(1'b0, 32'h0, 2'b10, 1'b1);
        step(1'b0, 32'h0, 2'b01, 1'b0);
        checks++;
        if (rd_words[63:32] !== 32'h0009_0000) begin
            errors++;
            $display("FAIL udf_status: got %h want %h", rd_words[63:32], 32'h0009_0000);
        end
        w = $urandom;
        step(1'b1, w, 2'b00, 1'b0);
        checks++;
        if (rd_words[31:0] !== w) begin
            errors++;
            $display("FAIL udf_ptr_unchanged: got %h want %h", rd_words[31:0], w);
        end
        for (int i = 0; i < 17; i++) step(1'b1, $urandom, 2'b00, 1'b0);
        checks++;
        if (rd_words[63:32] !== 32'h020E_0010) begin
            errors++;
            $display("FAIL drop2_status: got %h want %h", rd_words[63:32], 32'h020E_0010);
        end
        step(1'b1, $urandom, 2'b10, 1'b0);
        checks++;
        if (rd_words[63:32] !== 32'h0106_0010 || rd_words !== exp_words()) begin
            errors++;
            $display("FAIL clear_vs_drop: got %h want %h", rd_words[63:32], 32'h0106_0010);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 32'h0, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 2'b00, 1'b0);
        checks++;
        if (rd_words[63:32] !== 32'h0104_0005) begin
            errors++;
            $display("FAIL flush_fill5: got %h want %h", rd_words[63:32], 32'h0104_0005);
        end
        step(1'b1, $urandom, 2'b01, 1'b1);
        checks++;
        if (rd_words !== 64'h0105_0000_0000_0000) begin
            errors++;
            $display("FAIL flush_with_write: got %h want %h", rd_words, 64'h0105_0000_0000_0000);
        end
    endtask

    task automatic test_drop_saturate();
        step(1'b0, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 2'b00, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, $urandom, 2'b00, 1'b0);
        checks++;
        if (rd_words[63:56] !== 8'hFF || rd_words !== exp_words()) begin
            errors++;
            $display("FAIL drop_saturate: got %h want %h", rd_words, exp_words());
        end
        step(1'b0, 32'h0, 2'b10, 1'b1);
    endtask

    task automatic test_random();
        logic wv;
        logic fl;
        logic [1:0] ack;
        for (int i = 0; i < 400; i++) begin
            wv  = ($urandom_range(0, 9) < 6);
            ack[0] = ($urandom_range(0, 9) < 4);
            ack[1] = ($urandom_range(0, 19) == 0);
            fl  = ($urandom_range(0, 49) == 0);
            step(wv, $urandom, ack, fl);
            checks++;
            if (rd_words !== exp_words() || wr_ready !== (q.size() != 16)) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h rdy %b want %h", i, rd_words, wr_ready, exp_words());
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 2'b00, 1'b0);
        step(1'b1, $urandom, 2'b00, 1'b0);
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        read_ack = 2'b01;
        @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (rd_words !== 64'h0001_0000_0000_0000 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got %h rdy %b want %h", rd_words, wr_ready, 64'h0001_0000_0000_0000);
        end
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        read_ack = 2'b00;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        flush    = 1'b0;
        read_ack = 2'b00;
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_underflow_and_clear_race();
        test_flush();
        test_drop_saturate();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ah_pl2cpu_result_fifo.md
Name: ah_pl2cpu_result_fifo

Overview:
Upstream feeder for the CPU-read AXI-Lite slave. It buffers result words produced by PL logic (for example, ring-oscillator counter values) in a FIFO. It presents two 32-bit words on a packed bus, word 0 = FIFO head data and word 1 = status, and pops or clears on that slave's per-word read_ack pulses. The bus connects directly to an instance of the read slave built with USED_INPUTS = 2.

Parameters:
DATA_WIDTH, 32, width of each result word and of each packed output word
DEPTH_LOG2, 4, log2 of FIFO depth (depth 16); legal range 1..15

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESETN  in  1  synchronous reset, active low
wr_data  in  DATA_WIDTH  result word from PL producer
wr_valid  in  1  producer offers wr_data this cycle
wr_ready  out  1  FIFO not full
flush  in  1  PL-side flush of FIFO contents
rd_words  out  2*DATA_WIDTH  [DATA_WIDTH-1:0] = data word; [2*DATA_WIDTH-1:DATA_WIDTH] = status word
read_ack  in  2  bit0 = data word consumed by CPU; bit1 = status word consumed by CPU

Behaviour:
- Reset (S_AXI_ARESETN low at clock edge) clears the following:
  - wr/rd pointers = 0, count = 0
  - overflow = 0, underflow = 0, drop_cnt = 0
  - Outputs: wr_ready = 1, data word = 0, status word = 0x0001_0000 (empty bit set)
- Storage and pointers:
  - Storage: 2^DEPTH_LOG2 entries.
  - Pointers: DEPTH_LOG2 bits, wrap modulo depth.
  - count: DEPTH_LOG2+1 bits, 0..depth.
  - full = (count == depth); empty = (count == 0); wr_ready = ~full, derived from registered count only.
- Push = wr_valid & ~full & ~flush. The word is written at wr_ptr and wr_ptr increments. It is visible at the head the next cycle if the FIFO was empty.
- Drop = wr_valid & full & ~flush. The word is discarded, overflow is set, and drop_cnt increments, saturating at 255.
  - A write while full is dropped even if a pop occurs in the same cycle.
- Pop = read_ack[0] & ~empty & ~flush. rd_ptr increments.
  - read_ack[0] while empty sets underflow; no pointer change.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Data word:
  - Equals the head entry (mem[rd_ptr]) when not empty, else 0.
  - Combinational from registered pointer and storage, so it changes the cycle after a push into an empty FIFO or a pop.
- Status word, combinational from registers:
  - [15:0] count, zero-extended
  - [16] empty
  - [17] full
  - [18] overflow
  - [19] underflow
  - [23:20] 0
  - [31:24] drop_cnt
- Status clear: read_ack[1] clears overflow, underflow and drop_cnt.
  - If a drop occurs in the same cycle: overflow = 1 and drop_cnt = 1.
  - If an underflow occurs in the same cycle: underflow = 1.
  - The event wins.
- flush:
  - Pointers and count go to 0 in one cycle.
  - A concurrent push is discarded and not counted as a drop.
  - A concurrent pop or underflow is ignored.
  - Flags and drop_cnt are unaffected.
- Latency: push to visible head = 1 cycle. read_ack[0] to next head on rd_words = 1 cycle.
- No state machine beyond the pointer, count and flag registers. The consumer guarantees at most one read_ack pulse per CPU read.

Decomposition:
- Shared header/package holds:
  - STAT_COUNT_LSB = 0, STAT_EMPTY_BIT = 16, STAT_FULL_BIT = 17, STAT_OVF_BIT = 18, STAT_UDF_BIT = 19, STAT_DROP_LSB = 24
  - WORD_DATA = 0, WORD_STATUS = 1 (read_ack/rd_words indices)
- Sub-module ah_pl2cpu_regfile: simple dual-port register array with synchronous write and asynchronous read, parameters DATA_WIDTH and DEPTH_LOG2, no reset on storage.

Test Plan:
- Reset, then idle -> rd_words data = 0, status = 0x0001_0000, wr_ready = 1.
- Push 0xA1, 0xB2, 0xC3 on consecutive cycles -> head = 0xA1 one cycle after first push, status count = 3. Three read_ack[0] pulses -> head 0xB2, 0xC3, then 0, status empty.
- Push 17 words into depth 16 -> wr_ready = 0 after the 16th; 17th dropped; status = 0x0106_0010 (drop_cnt 1, full, overflow, count 16). read_ack[1] -> overflow and drop_cnt cleared, status = 0x0002_0010.
- Fill to 8, then push and pop in the same cycle for 20 cycles -> count stays 8; data order preserved across pointer wrap.
- read_ack[0] on an empty FIFO -> underflow bit set, pointers unchanged. read_ack[1] with a simultaneous drop while full -> overflow = 1, drop_cnt = 1.
- Fill to 5, assert flush together with wr_valid -> count = 0, empty = 1, drop_cnt unchanged. Reset asserted mid-stream -> all registers return to reset values in that cycle.
